// File: rtl/rv_wb_pkg.sv
// Shared types for the integer register-file writeback path: widths, buffered result entry, hazard helpers.
package rv_wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    typedef struct packed {
        reg_addr_t rd;
        xdata_t    data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        HAZ_NONE = 2'b00,
        HAZ_RAW  = 2'b01,
        HAZ_WAW  = 2'b10,
        HAZ_BOTH = 2'b11
    } haz_e;

    // x0 is never a real destination.
    function automatic logic rd_live(input reg_addr_t rd);
        return rd != '0;
    endfunction

    function automatic logic src_stall(input logic busy, input logic fwd_hit);
        return busy & ~fwd_hit;
    endfunction

    function automatic haz_e haz_encode(input logic raw, input logic waw);
        return haz_e'({waw, raw});
    endfunction

endpackage

// File: rtl/rf_writeback_unit_if.sv
// Core-facing bundle of the writeback unit: ALU/issue/MUL-DIV inputs, RF write port, hazards.
// Forwarding outputs exist only when RF_WB_FWD_EN is defined.
interface rf_writeback_unit_if;
    import rv_wb_pkg::*;

    logic      alu_we_i;
    reg_addr_t alu_rd_i;
    xdata_t    alu_data_i;
    logic      issue_i;
    reg_addr_t issue_rd_i;
    logic      md_valid_i;
    logic      md_ready_o;
    reg_addr_t md_rd_i;
    xdata_t    md_data_i;
    reg_addr_t rs1_addr_i;
    reg_addr_t rs2_addr_i;
    logic      raw_hazard_o;
    logic      waw_hazard_o;
    logic      rf_we_o;
    reg_addr_t rf_rd_o;
    xdata_t    rf_data_o;
`ifdef RF_WB_FWD_EN
    logic      fwd_rs1_valid_o;
    xdata_t    fwd_rs1_data_o;
    logic      fwd_rs2_valid_o;
    xdata_t    fwd_rs2_data_o;
`endif

    modport slave (
        input  alu_we_i, alu_rd_i, alu_data_i, issue_i, issue_rd_i,
               md_valid_i, md_rd_i, md_data_i, rs1_addr_i, rs2_addr_i,
        output md_ready_o, raw_hazard_o, waw_hazard_o, rf_we_o, rf_rd_o, rf_data_o
`ifdef RF_WB_FWD_EN
        , output fwd_rs1_valid_o, fwd_rs1_data_o, fwd_rs2_valid_o, fwd_rs2_data_o
`endif
    );

    modport master (
        output alu_we_i, alu_rd_i, alu_data_i, issue_i, issue_rd_i,
               md_valid_i, md_rd_i, md_data_i, rs1_addr_i, rs2_addr_i,
        input  md_ready_o, raw_hazard_o, waw_hazard_o, rf_we_o, rf_rd_o, rf_data_o
`ifdef RF_WB_FWD_EN
        , input fwd_rs1_valid_o, fwd_rs1_data_o, fwd_rs2_valid_o, fwd_rs2_data_o
`endif
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small FIFO of buffered MUL/DIV results; write-to-read latency 1 cycle, push ignored when full.
// Also exposes every entry oldest-first so the top can forward the youngest match.
module wb_result_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset_ni,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty,
    output wb_entry_t vis_entry [DEPTH],
    output logic [DEPTH-1:0] vis_valid
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] count;
    wb_entry_t   mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= push_entry;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_vis
        logic [PW-1:0] idx;
        assign idx          = rd_ptr[PW-1:0] + PW'(g);
        assign vis_entry[g] = mem[idx];
        assign vis_valid[g] = ((PW+1)'(g) < count);
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Merges ALU and buffered MUL/DIV results onto the single RF write port (ALU zero latency, MUL/DIV >=1 cycle),
// backpressures MUL/DIV via md_ready_o, tracks busy rds for hazards. RF_WB_FWD_EN adds buffered-result forwarding.
module rf_writeback_unit
    import rv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input logic clk,
    input logic reset_ni,
    rf_writeback_unit_if.slave bus
);

    logic                alu_eff;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    wb_entry_t           fifo_head;
    wb_entry_t           push_entry;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                fwd1_hit;
    logic                fwd2_hit;
    logic                raw;
    logic                waw;
    haz_e                haz;

    assign alu_eff    = bus.alu_we_i & rd_live(bus.alu_rd_i);
    assign fifo_pop   = ~alu_eff & ~fifo_empty;
    // Results for x0 are handshaken but dropped.
    assign fifo_push  = bus.md_valid_i & ~fifo_full & rd_live(bus.md_rd_i);
    assign push_entry = '{rd: bus.md_rd_i, data: bus.md_data_i};
    assign bus.md_ready_o = ~fifo_full;

`ifdef RF_WB_FWD_EN
    wb_entry_t             vis_entry [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vis_valid;
`endif

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_ni   (reset_ni),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
`ifdef RF_WB_FWD_EN
        .vis_entry  (vis_entry),
        .vis_valid  (vis_valid)
`else
        .vis_entry  (),
        .vis_valid  ()
`endif
    );

    always_comb begin
        bus.rf_we_o   = 1'b0;
        bus.rf_rd_o   = '0;
        bus.rf_data_o = '0;
        if (reset_ni) begin
            if (alu_eff) begin
                bus.rf_we_o   = 1'b1;
                bus.rf_rd_o   = bus.alu_rd_i;
                bus.rf_data_o = bus.alu_data_i;
            end else if (!fifo_empty) begin
                bus.rf_we_o   = 1'b1;
                bus.rf_rd_o   = fifo_head.rd;
                bus.rf_data_o = fifo_head.data;
            end
        end
    end

    // Clear first so a same-cycle issue to the retiring rd keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
        if (bus.issue_i && rd_live(bus.issue_rd_i)) busy_d[bus.issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) busy_q <= '0;
        else           busy_q <= busy_d;
    end

`ifdef RF_WB_FWD_EN
    xdata_t fwd1_dat;
    xdata_t fwd2_dat;

    // Later (younger) entries override older matches.
    always_comb begin
        fwd1_hit = 1'b0;
        fwd1_dat = '0;
        fwd2_hit = 1'b0;
        fwd2_dat = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vis_valid[i] && rd_live(bus.rs1_addr_i) && vis_entry[i].rd == bus.rs1_addr_i) begin
                fwd1_hit = 1'b1;
                fwd1_dat = vis_entry[i].data;
            end
            if (vis_valid[i] && rd_live(bus.rs2_addr_i) && vis_entry[i].rd == bus.rs2_addr_i) begin
                fwd2_hit = 1'b1;
                fwd2_dat = vis_entry[i].data;
            end
        end
    end

    assign bus.fwd_rs1_valid_o = fwd1_hit;
    assign bus.fwd_rs1_data_o  = fwd1_dat;
    assign bus.fwd_rs2_valid_o = fwd2_hit;
    assign bus.fwd_rs2_data_o  = fwd2_dat;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
`endif

    assign raw = src_stall(busy_q[bus.rs1_addr_i], fwd1_hit)
               | src_stall(busy_q[bus.rs2_addr_i], fwd2_hit);
    assign waw = (bus.issue_i & busy_q[bus.issue_rd_i])
               | (bus.alu_we_i & busy_q[bus.alu_rd_i]);
    assign haz = haz_encode(raw, waw);

    assign bus.raw_hazard_o = haz[0];
    assign bus.waw_hazard_o = haz[1];

    // Issuing to a busy rd is only tolerated when that rd retires in the same cycle.
    issue_to_busy_a: assert property (@(posedge clk) disable iff (!reset_ni)
        (bus.issue_i && rd_live(bus.issue_rd_i) && busy_q[bus.issue_rd_i])
        |-> (fifo_pop && fifo_head.rd == bus.issue_rd_i));

endmodule

// File: doc/rf_writeback_unit.md
Name: rf_writeback_unit

Overview:
- Writer side of the integer register file.
- Merges single-cycle ALU results with long-latency MUL/DIV (M-extension) results into the register file's single write port.
- Buffers MUL/DIV results in a small FIFO and keeps a busy scoreboard per architectural register.
- Reports RAW/WAW hazards to the core's stall logic.

Parameters:
- XLEN, 32, data width of results and register-file write data.
- REG_AW, 5, register address width (2**REG_AW registers; x0 hardwired zero).
- FIFO_DEPTH, 2, MUL/DIV result buffer entries (power of two, >=2).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- alu_we_i  in  1  ALU result write request this cycle.
- alu_rd_i  in  REG_AW  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- issue_i  in  1  long MUL/DIV op issued this cycle.
- issue_rd_i  in  REG_AW  destination of the issued long op.
- md_valid_i  in  1  MUL/DIV result valid.
- md_ready_o  out  1  buffer can accept a result.
- md_rd_i  in  REG_AW  MUL/DIV result destination.
- md_data_i  in  XLEN  MUL/DIV result.
- rs1_addr_i  in  REG_AW  decode-stage source 1.
- rs2_addr_i  in  REG_AW  decode-stage source 2.
- raw_hazard_o  out  1  a source register is busy.
- waw_hazard_o  out  1  ALU or issue destination is busy.
- rf_we_o  out  1  register-file write enable.
- rf_rd_o  out  REG_AW  register-file write address.
- rf_data_o  out  XLEN  register-file write data.

Behaviour:
- Reset is asynchronous, active-low on reset_ni; clk is the only clock.
- Reset values:
  - FIFO empty; all busy bits 0.
  - md_ready_o=1, raw_hazard_o=0, waw_hazard_o=0.
  - rf_we_o=0, rf_rd_o=0, rf_data_o=0 (outputs gated to 0 while reset_ni=0).
- Write-port arbitration (combinational):
  - ALU write is effective when alu_we_i=1 and alu_rd_i!=0.
  - Effective ALU write always wins: rf_* = ALU fields, zero latency.
  - Otherwise, if the FIFO is non-empty: rf_* = head entry, and the head is popped at the clock edge.
  - Otherwise rf_we_o=0 and rf_rd_o/rf_data_o hold 0.
- FIFO:
  - md_ready_o = !full.
  - Push on md_valid_i && md_ready_o.
  - md_rd_i==0 is accepted but not pushed.
  - No bypass: minimum 1 cycle from md acceptance to rf write.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard busy[1:2**REG_AW-1]:
  - Set at the edge on issue_i with issue_rd_i!=0.
  - Cleared at the edge when a FIFO entry for that rd is written.
  - Set and clear of the same rd in one cycle: set wins.
  - busy[0] is constant 0.
- Hazards (combinational):
  - raw_hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i].
  - waw_hazard_o = (issue_i & busy[issue_rd_i]) | (alu_we_i & busy[alu_rd_i]).
  - The core stalls on either hazard.
  - issue_i to a busy rd is a protocol violation: flagged by assertion, scoreboard unchanged.
- Reset mid-operation: buffered results and busy bits are discarded immediately; no partial writes.
- Starvation under continuous ALU writes is accepted. Backpressure reaches the MUL/DIV unit via md_ready_o.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - Adds outputs fwd_rs1_valid_o/fwd_rs1_data_o and fwd_rs2_valid_o/fwd_rs2_data_o.
  - When a FIFO entry matches rsN (nonzero), the youngest match is forwarded and that source no longer contributes to raw_hazard_o.
  - A busy register with no buffered result still raises the hazard.
- Undefined: ports absent; raw_hazard_o purely from busy bits.

Decomposition:
- Package rv_wb_pkg holds:
  - XLEN and REG_AW constants.
  - wb_entry_t struct {rd, data}.
  - Hazard encoding helpers.
- One sub-module, wb_result_fifo: generic FIFO of wb_entry_t with full/empty, push/pop, and an entry-visibility port for forwarding.
- Scoreboard and arbitration stay in the top module.

Test Plan:
- Reset, then md result (rd=5, data=0xDEAD_BEEF), alu_we_i=0 → next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF; FIFO empty afterwards.
- issue_i rd=7, then rs1_addr_i=7 → raw_hazard_o=1 until the md result for rd=7 is written, then 0 the following cycle.
- ALU writes every cycle (rd=3) while two md results arrive → md_ready_o=0 after 2 pushes; third held by valid/ready; drains in order once alu_we_i drops.
- Same-cycle clear and new issue_i for rd=9 → busy[9] stays 1.
- md_rd_i=0, alu_rd_i=0, issue_rd_i=0 → no rf write, no busy bit, no hazard.
- reset_ni pulsed low with 2 entries buffered → rf_we_o=0 at once, md_ready_o=1, all hazards 0; with RF_WB_FWD_EN, a buffered rd=4 forwards to rs2=4 with raw_hazard_o=0 before reset.
